// File: rtl/rram_read_seq.sv
// -----------------------------------------------------------------------------
// rram_read_seq
//   Read sequencer placed directly in front of the rram_1p3Mb analog macro.
//   Takes one read request at a time (valid/ready), drives the macro's
//   address, references, DAC codes and read enables, waits the programmed
//   setup time, runs the sa_en / sa_clk sense sequence, waits for the
//   synchronised sa_rdy (with timeout) and returns one masked response word.
//   Write-side macro pins are tied inactive; writes belong to another block.
//
// Ports
//   mclk, rst_n            block clock, asynchronous active-low reset
//   req_*                  read request channel (req_ready high only in IDLE)
//   rsp_*                  response channel; rsp_timeout=1 means sa_rdy was
//                          never seen and rsp_data is 0
//   rram_addr .. wl_dac_config, di
//                          registered copies of the latched request fields
//   set_rst                tied 1 so the macro's internal mask equals di
//   wl_en .. wl_dac_en     read enables, high from SETUP until WAIT ends
//   we, aclk, bsl_dac_en   write-side controls, tied 0
//   sa_en, sa_clk          sense-amp controls
//   sa_rdy                 sense done, asynchronous to mclk
//   sa_do                  sense data, sampled only after synchronised sa_rdy
// -----------------------------------------------------------------------------
`ifndef ADDR_BITS_N
`define ADDR_BITS_N 15
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef ADC_BITS_N
`define ADC_BITS_N 6
`endif
`ifndef READ_DAC_BITS_N
`define READ_DAC_BITS_N 4
`endif
`ifndef WL_DAC_BITS_N
`define WL_DAC_BITS_N 4
`endif

module rram_read_seq #(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                          mclk,
  input  logic                          rst_n,
  // request channel
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [`ADDR_BITS_N-1:0]       req_addr,
  input  logic [`WORD_SIZE-1:0]         req_mask,
  input  logic [`ADC_BITS_N-1:0]        req_read_ref,
  input  logic [`ADC_BITS_N-1:0]        req_clamp_ref,
  input  logic [`READ_DAC_BITS_N-1:0]   req_read_dac,
  input  logic [`WL_DAC_BITS_N-1:0]     req_wl_dac,
  // response channel
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [`WORD_SIZE-1:0]         rsp_data,
  output logic                          rsp_timeout,
  // macro-facing pins
  output logic [`ADDR_BITS_N-1:0]       rram_addr,
  output logic [`ADC_BITS_N-1:0]        read_ref,
  output logic [`ADC_BITS_N-1:0]        clamp_ref,
  output logic [`READ_DAC_BITS_N-1:0]   read_dac_config,
  output logic [`WL_DAC_BITS_N-1:0]     wl_dac_config,
  output logic [`WORD_SIZE-1:0]         di,
  output logic                          set_rst,
  output logic                          wl_en,
  output logic                          bl_en,
  output logic                          sl_en,
  output logic                          bleed_en,
  output logic                          read_dac_en,
  output logic                          wl_dac_en,
  output logic                          we,
  output logic                          aclk,
  output logic                          bsl_dac_en,
  output logic                          sa_en,
  output logic                          sa_clk,
  input  logic                          sa_rdy,
  input  logic [`WORD_SIZE-1:0]         sa_do
);

  // ---------------------------------------------------------------------------
  // Parameter range guards
  // ---------------------------------------------------------------------------
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
    $error("rram_read_seq: SETUP_CYCLES must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rram_read_seq: TIMEOUT_CYCLES must be in 1..255");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("rram_read_seq: SYNC_STAGES must be in 2..3");
  end

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SENSE = 3'd2;
  localparam logic [2:0] ST_PULSE = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  localparam logic [3:0] SETUP_LAST   = 4'(SETUP_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0]             state;
  logic [2:0]             state_nx;
  logic [3:0]             setup_cnt;
  logic [7:0]             wait_cnt;
  logic [SYNC_STAGES-1:0] rdy_pipe;
  logic                   rdy_sync;
  logic [5:0]             en_q;
  logic                   accept;
  logic                   setup_done;
  logic                   wait_expired;

  assign rdy_sync     = rdy_pipe[SYNC_STAGES-1];
  assign accept       = req_valid & req_ready;
  assign setup_done   = (setup_cnt == SETUP_LAST);
  assign wait_expired = (wait_cnt == TIMEOUT_LAST);

  // Write-side pins are never exercised by this block.
  assign we         = 1'b0;
  assign aclk       = 1'b0;
  assign bsl_dac_en = 1'b0;
  assign set_rst    = 1'b1;

  assign {wl_en, bl_en, sl_en, bleed_en, read_dac_en, wl_dac_en} = en_q;

  // ---------------------------------------------------------------------------
  // sa_rdy synchroniser
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_pipe <= '0;
    end else begin
      rdy_pipe <= {rdy_pipe[SYNC_STAGES-2:0], sa_rdy};
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_SETUP;
      ST_SETUP: if (setup_done) state_nx = ST_SENSE;
      ST_SENSE: state_nx = ST_PULSE;
      ST_PULSE: state_nx = ST_WAIT;
      ST_WAIT:  if (rdy_sync || wait_expired) state_nx = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      setup_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nx;
      // Both counters self-clear whenever their state is not active, so the
      // WAIT counter is already zero on the first WAIT cycle.
      setup_cnt <= (state == ST_SETUP) ? setup_cnt + 4'd1 : '0;
      wait_cnt  <= (state == ST_WAIT)  ? wait_cnt + 8'd1  : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control outputs: registered from the next state so each pin changes on
  // the same edge that enters the state that owns it, with no input-to-pin
  // combinational path.
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      en_q      <= '0;
      sa_en     <= 1'b0;
      sa_clk    <= 1'b0;
    end else begin
      req_ready <= (state_nx == ST_IDLE);
      rsp_valid <= (state_nx == ST_RESP);
      en_q      <= (state_nx == ST_SETUP || state_nx == ST_SENSE ||
                    state_nx == ST_PULSE || state_nx == ST_WAIT) ? '1 : '0;
      sa_en     <= (state_nx == ST_SENSE || state_nx == ST_PULSE ||
                    state_nx == ST_WAIT);
      sa_clk    <= (state_nx == ST_PULSE);
    end
  end

  // ---------------------------------------------------------------------------
  // Request field latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rram_addr       <= '0;
      read_ref        <= '0;
      clamp_ref       <= '0;
      read_dac_config <= '0;
      wl_dac_config   <= '0;
      di              <= '0;
    end else if (state == ST_IDLE && accept) begin
      rram_addr       <= req_addr;
      read_ref        <= req_read_ref;
      clamp_ref       <= req_clamp_ref;
      read_dac_config <= req_read_dac;
      wl_dac_config   <= req_wl_dac;
      di              <= req_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Response capture. rdy wins over an expiring timeout. Masked-off bits are
  // ANDed away so an undriven sa_do bit can never reach rsp_data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (rdy_sync) begin
        rsp_data    <= sa_do & di;
        rsp_timeout <= 1'b0;
      end else if (wait_expired) begin
        rsp_data    <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rram_read_seq.sv
`ifndef ADDR_BITS_N
`define ADDR_BITS_N 15
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef ADC_BITS_N
`define ADC_BITS_N 6
`endif
`ifndef READ_DAC_BITS_N
`define READ_DAC_BITS_N 4
`endif
`ifndef WL_DAC_BITS_N
`define WL_DAC_BITS_N 4
`endif

module tb_rram_read_seq;
  localparam int SETUP = 2;
  localparam int TMO   = 32;
  localparam int SYNC  = 2;

  logic                        mclk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        req_valid, req_ready;
  logic [`ADDR_BITS_N-1:0]     req_addr;
  logic [`WORD_SIZE-1:0]       req_mask;
  logic [`ADC_BITS_N-1:0]      req_read_ref, req_clamp_ref;
  logic [`READ_DAC_BITS_N-1:0] req_read_dac;
  logic [`WL_DAC_BITS_N-1:0]   req_wl_dac;
  logic                        rsp_valid, rsp_ready, rsp_timeout;
  logic [`WORD_SIZE-1:0]       rsp_data;
  logic [`ADDR_BITS_N-1:0]     rram_addr;
  logic [`ADC_BITS_N-1:0]      read_ref, clamp_ref;
  logic [`READ_DAC_BITS_N-1:0] read_dac_config;
  logic [`WL_DAC_BITS_N-1:0]   wl_dac_config;
  logic [`WORD_SIZE-1:0]       di;
  logic set_rst, wl_en, bl_en, sl_en, bleed_en, read_dac_en, wl_dac_en;
  logic we, aclk, bsl_dac_en, sa_en, sa_clk, sa_rdy;
  logic [`WORD_SIZE-1:0]       sa_do;

  rram_read_seq #(
    .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)
  ) dut (
    .mclk(mclk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_mask(req_mask), .req_read_ref(req_read_ref),
    .req_clamp_ref(req_clamp_ref), .req_read_dac(req_read_dac),
    .req_wl_dac(req_wl_dac),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .rram_addr(rram_addr), .read_ref(read_ref), .clamp_ref(clamp_ref),
    .read_dac_config(read_dac_config), .wl_dac_config(wl_dac_config),
    .di(di), .set_rst(set_rst),
    .wl_en(wl_en), .bl_en(bl_en), .sl_en(sl_en), .bleed_en(bleed_en),
    .read_dac_en(read_dac_en), .wl_dac_en(wl_dac_en),
    .we(we), .aclk(aclk), .bsl_dac_en(bsl_dac_en),
    .sa_en(sa_en), .sa_clk(sa_clk), .sa_rdy(sa_rdy), .sa_do(sa_do)
  );

  always #5 mclk = ~mclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [`WORD_SIZE-1:0] data;
    logic                  tmo;
  } rsp_t;
  rsp_t exp_q[$];

  // Behavioural cell conductance; address 5 is preset high on every bit.
  function automatic logic [5:0] cell_g(input logic [`ADDR_BITS_N-1:0] a,
                                        input int b);
    int v;
    if (a == 5) return 6'(40 + b);
    v = int'(a) * 37 + b * 19 + int'(a >> 3);
    return 6'(v % 64);
  endfunction

  logic [5:0] en6;
  assign en6 = {wl_en, bl_en, sl_en, bleed_en, read_dac_en, wl_dac_en};

  // Macro model: answers rdy_delay cycles after the sa_clk pulse.
  bit rdy_en;
  int rdy_delay;
  int cd;
  initial begin
    sa_rdy = 1'b0;
    sa_do  = '0;
    cd     = -1;
    forever begin
      @(posedge mclk);
      #2;
      if (!rst_n || !sa_en) begin
        sa_rdy = 1'b0;
        cd     = -1;
      end else begin
        if (sa_clk) cd = rdy_delay;
        else if (cd > 0) cd--;
        if (cd == 0 && rdy_en && !sa_rdy) begin
          for (int b = 0; b < `WORD_SIZE; b++)
            sa_do[b] = di[b] ? (cell_g(rram_addr, b) >= read_ref) : 1'bx;
          sa_rdy = 1'b1;
          cd     = -1;
        end
      end
    end
  end

  // Write-side pins must never move.
  int wr_viol = 0;
  always @(negedge mclk) if (we || aclk || bsl_dac_en || !set_rst) wr_viol++;

  task automatic set_fields(input logic [`ADDR_BITS_N-1:0] a,
                            input logic [`WORD_SIZE-1:0] m,
                            input logic [5:0] r);
    req_addr      = a;
    req_mask      = m;
    req_read_ref  = r;
    req_clamp_ref = r ^ 6'h2A;
    req_read_dac  = a[3:0];
    req_wl_dac    = ~a[3:0];
  endtask

  // Drive a request (called just after a negedge), check accept, the
  // latched pins and the sa_en / sa_clk timing; ends on the PULSE cycle.
  task automatic issue(input logic [`ADDR_BITS_N-1:0] a,
                       input logic [`WORD_SIZE-1:0] m,
                       input logic [5:0] r, output int waited);
    rsp_t e;
    int   n;
    e.data = '0;
    for (int b = 0; b < `WORD_SIZE; b++)
      if (rdy_en && m[b] && cell_g(a, b) >= r) e.data[b] = 1'b1;
    e.tmo = !rdy_en;
    exp_q.push_back(e);
    set_fields(a, m, r);
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 100) begin
      @(negedge mclk);
      waited++;
    end
    if (waited >= 100) begin
      check("accept_wait", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(negedge mclk);
    req_valid = 1'b0;
    check("lat_addr", rram_addr, a);
    check("lat_di", di, m);
    check("lat_refs", {read_ref, clamp_ref}, {r, r ^ 6'h2A});
    check("lat_dacs", {read_dac_config, wl_dac_config}, {a[3:0], ~a[3:0]});
    check("setup_en", {en6, sa_en, req_ready}, {6'h3F, 1'b0, 1'b0});
    n = 1;
    while (!sa_en && n < 20) begin
      @(negedge mclk);
      n++;
    end
    check("sa_en_lat", n, SETUP + 1);
    @(negedge mclk);
    check("sa_clk_pulse", {sa_clk, sa_en}, 2'b11);
  endtask

  // Wait for the response, check latency and data, apply backpressure.
  task automatic collect(input int bp);
    int   k, rdy_at;
    rsp_t e;
    logic [`WORD_SIZE:0] held;
    k = 0;
    rdy_at = sa_rdy ? 0 : -1;
    while (!rsp_valid && k < 300) begin
      @(negedge mclk);
      k++;
      if (sa_rdy && rdy_at < 0) rdy_at = k;
    end
    if (!rsp_valid) begin
      check("rsp_wait", 0, 1);
      return;
    end
    if (rdy_at >= 0) check("rsp_lat", k - rdy_at, SYNC + 1);
    else             check("tmo_lat", k, TMO + 1);
    check("resp_en_off", {en6, sa_en, sa_clk}, 0);
    if (exp_q.size() == 0) begin
      check("sb_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check("rsp_data", rsp_data, e.data);
    check("rsp_timeout", rsp_timeout, e.tmo);
    held = {rsp_timeout, rsp_data};
    for (int i = 0; i < bp; i++) begin
      @(negedge mclk);
      check("bp_hold", {rsp_valid, req_ready, rsp_timeout, rsp_data},
            {1'b1, 1'b0, held});
    end
    rsp_ready = 1'b1;
    @(negedge mclk);
    rsp_ready = 1'b0;
    check("post_hs", {rsp_valid, req_ready}, 2'b01);
  endtask

  int w;
  int seen;

  initial begin
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    set_fields('0, '0, '0);
    rdy_en    = 1'b1;
    rdy_delay = 1;

    repeat (3) @(negedge mclk);
    check("rst_ctrl", {req_ready, set_rst, rsp_valid, sa_en, sa_clk, en6},
          {2'b11, 9'h0});
    check("rst_fields", {rram_addr, di, rsp_data, rsp_timeout}, 0);
    rst_n = 1'b1;
    @(negedge mclk);

    // single full-mask read, then partial mask with X on masked bits
    issue(15'h0005, 16'hFFFF, 6'd20, w);
    collect(0);
    issue(15'h0005, 16'h00FF, 6'd20, w);
    collect(0);

    // timeout with backpressure; a new request waits during RESP
    rdy_en = 1'b0;
    issue(15'h0123, 16'hFFFF, 6'd10, w);
    set_fields(15'h0042, 16'hF0F0, 6'd25);
    req_valid = 1'b1;
    collect(10);
    rdy_en = 1'b1;
    issue(15'h0042, 16'hF0F0, 6'd25, w);
    check("accept_first_idle", w, 0);
    collect(0);

    // reset while waiting for sa_rdy
    rdy_en = 1'b0;
    issue(15'h0777, 16'hFFFF, 6'd30, w);
    repeat (4) @(negedge mclk);
    check("in_wait", {sa_en, en6}, 7'h7F);
    @(posedge mclk);
    #3 rst_n = 1'b0;
    #1 check("async_drop", {sa_en, sa_clk, en6, rsp_valid}, 0);
    check("async_ready", req_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
    seen = 0;
    repeat (TMO + 10) begin
      @(negedge mclk);
      if (rsp_valid) seen++;
    end
    check("no_rsp_after_rst", seen, 0);
    rdy_en = 1'b1;
    issue(15'h0005, 16'hA5A5, 6'd20, w);
    collect(0);

    // back-to-back random reads
    for (int i = 0; i < 8; i++) begin
      rdy_delay = $urandom_range(0, 4);
      issue(15'($urandom), 16'($urandom), 6'($urandom_range(0, 63)), w);
      collect($urandom_range(0, 2));
    end

    check("write_pins_idle", wr_viol, 0);
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rram_read_seq.md
Name: rram_read_seq

Overview:
- Digital read sequencer sitting directly upstream of the rram_1p3Mb analog macro.
- Accepts one read request at a time over a valid/ready interface and drives the macro's address, reference, DAC config and enable pins, holding them for a programmed setup time.
- Generates the sa_en / sa_clk sense sequence, waits for the synchronised sa_rdy with a timeout, captures sa_do under a per-bit mask and returns one response word.
- Write-side macro pins are driven inactive by this block; writes are owned by a separate block.

Parameters:
- SETUP_CYCLES, 2, cycles between enable/address assertion and sa_en rising (≥19 ns at 100 MHz); legal range 1..15.
- TIMEOUT_CYCLES, 32, maximum cycles spent in WAIT before aborting; legal range 1..255.
- SYNC_STAGES, 2, flop stages on the sa_rdy synchroniser; legal 2..3.

Ports:
- mclk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  read request valid
- req_ready  out  1  high only in IDLE
- req_addr  in  `ADDR_BITS_N  word address
- req_mask  in  `WORD_SIZE  1 = bit is read, 0 = bit forced 0 in response
- req_read_ref  in  `ADC_BITS_N  sense threshold
- req_clamp_ref  in  `ADC_BITS_N  clamp reference
- req_read_dac  in  `READ_DAC_BITS_N  read DAC code
- req_wl_dac  in  `WL_DAC_BITS_N  WL DAC code
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_data  out  `WORD_SIZE  captured sa_do AND mask
- rsp_timeout  out  1  sa_rdy never seen; rsp_data = 0
- rram_addr, read_ref, clamp_ref, read_dac_config, wl_dac_config  out  (widths as above)  registered copies of the request fields
- di  out  `WORD_SIZE  = latched mask
- set_rst  out  1  held at 1 so the macro's internal mask equals di
- wl_en, bl_en, sl_en, bleed_en, read_dac_en, wl_dac_en  out  1  read enables
- we, aclk, bsl_dac_en  out  1  constant 0
- sa_en, sa_clk  out  1  sense controls
- sa_rdy  in  1  asynchronous to mclk
- sa_do  in  `WORD_SIZE  sense data, sampled only after synchronised sa_rdy

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - All outputs 0 except req_ready = 1 and set_rst = 1.
  - Counters, synchroniser and latched fields are cleared.
  - A reset asserted mid-operation drops every enable, sa_en and sa_clk immediately, with no response issued.
- Every macro-facing output is driven from a flop; there are no combinational paths from inputs to macro pins.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch all request fields and go to SETUP.
- SETUP:
  - Registered outputs and all six enables are high from the first SETUP cycle.
  - Counter runs 0..SETUP_CYCLES-1, then go to SENSE.
- SENSE (1 cycle): sa_en = 1. Go to PULSE.
- PULSE (1 cycle): sa_clk = 1, sa_en stays 1. Go to WAIT; the WAIT counter clears.
- WAIT:
  - sa_clk = 0, sa_en = 1.
  - On rdy_sync = 1: capture rsp_data = sa_do & mask, set rsp_timeout = 0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: set rsp_data = 0, rsp_timeout = 1, go to RESP.
  - If rdy_sync rises on the same cycle as the timeout, rdy takes priority (no timeout).
- RESP:
  - rsp_valid = 1.
  - sa_en and all enables are 0 from the first RESP cycle.
  - rsp_data and rsp_timeout are held stable until rsp_valid & rsp_ready; then return to IDLE.
  - A new request cannot be accepted in the same cycle as the handshake (req_ready is 1 only in IDLE).
- Latency: with accept at cycle 0, sa_en rises at cycle SETUP_CYCLES+1, sa_clk pulses at SETUP_CYCLES+2, and the response is valid SYNC_STAGES+1 cycles after sa_rdy rises.
- X handling: sa_do bits with mask = 0 never propagate; rsp_data for those bits is 0 even if sa_do is X.
- sa_rdy high while not in WAIT is ignored; no assertion fires.
- Parameters outside their legal range trigger a simulation-time elaboration error.

Test Plan:
- Reset then single read: addr=0x0005, mask=all-1, ref=20, macro cells preset ≥20 → rsp_data all 1, rsp_timeout=0; sa_en rises exactly 3 cycles after accept with SETUP_CYCLES=2.
- Partial mask: mask=0x00FF on a 16-bit view, all cells ≥ ref → rsp_data=0x00FF; upper bits 0 despite X on sa_do.
- Timeout: sa_rdy tied low, TIMEOUT_CYCLES=32 → rsp_valid with rsp_timeout=1, rsp_data=0; enables low in the same cycle rsp_valid rises.
- Backpressure: rsp_ready held low 10 cycles → rsp_data stable, req_ready=0, new req_valid not accepted; the request is accepted on the first cycle back in IDLE.
- Reset mid-WAIT: rst_n low while sa_en=1 → sa_en, sa_clk and enables go to 0 asynchronously; rsp_valid never asserts; next request completes normally.
- Back-to-back: 8 reads at random addresses and refs against the behavioural macro → each rsp_data equals the model's (g ≥ ref) vector under mask; we and aclk stay 0 throughout.
